// File: rtl/adc_seq_ctrl_pkg.sv
// adc_ctrl_pkg: shared widths and FSM state encoding for the ADC sequencer
package adc_ctrl_pkg;
    localparam int ADC_DW = 12;
    localparam int CNT_W  = 16;
    typedef enum logic [2:0] {
        IDLE,
        START_HI,
        WAIT_EOC_LO,
        WAIT_EOC_HI,
        OE_HI,
        CAPTURE
    } state_e;
endpackage

// File: rtl/adc_seq_ctrl_if.sv
// adc_seq_ctrl_if: start/EOC/OE/data handshake between sequencer and ADC
interface adc_seq_ctrl_if;
    logic                             adc_start;
    logic                             adc_oe;
    logic                             adc_eoc;
    logic [adc_ctrl_pkg::ADC_DW-1:0]  adc_data;
    modport master (output adc_start, adc_oe, input adc_eoc, adc_data);
    modport slave  (input adc_start, adc_oe, output adc_eoc, adc_data);
endinterface

// File: rtl/adc_seq_ctrl_tick_gen.sv
// adc_tick_gen: free-running period counter producing one tick per SAMPLE_PERIOD cycles
module adc_tick_gen
    import adc_ctrl_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tick
);
    logic [CNT_W-1:0] cnt_q;
    assign tick = en && cnt_q == CNT_W'(SAMPLE_PERIOD - 1);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= (!en || tick) ? '0 : cnt_q + CNT_W'(1);
    end
endmodule

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: sequences ADC start/EOC/OE handshake and delivers captured samples
module adc_seq_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int START_WIDTH   = 2,
    parameter int OE_WIDTH      = 2,
    parameter int TIMEOUT       = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              soft_trig,
    input  logic              err_clr,
    adc_seq_ctrl_if.master    adc,
    output logic [ADC_DW-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic [CNT_W-1:0]  sample_cnt
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [ADC_DW-1:0] sample_q;
    logic              tick, req, to_set, expired;
    logic              start_q, oe_q, busy_q, valid_q, to_q, ov_q;

    adc_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .tick (tick)
    );

    assign req     = tick | soft_trig;
    assign expired = wcnt_q == '0;

    // One down-counter times every phase; it is reloaded whenever the state changes.
    always_comb begin
        state_d = state_q;
        to_set  = 1'b0;
        case (state_q)
            IDLE:        state_d = req ? START_HI : IDLE;
            START_HI:    state_d = expired ? WAIT_EOC_LO : START_HI;
            WAIT_EOC_LO: begin
                state_d = !adc.adc_eoc ? WAIT_EOC_HI : expired ? IDLE : WAIT_EOC_LO;
                to_set  = adc.adc_eoc && expired;
            end
            WAIT_EOC_HI: begin
                state_d = adc.adc_eoc ? OE_HI : expired ? IDLE : WAIT_EOC_HI;
                to_set  = !adc.adc_eoc && expired;
            end
            OE_HI:       state_d = expired ? CAPTURE : OE_HI;
            CAPTURE:     state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        wcnt_d = state_d != state_q ? (state_d == START_HI ? CNT_W'(START_WIDTH - 1) :
                                       state_d == OE_HI    ? CNT_W'(OE_WIDTH - 1)    :
                                                             CNT_W'(TIMEOUT - 1))    :
                 state_q == IDLE    ? wcnt_q : wcnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            start_q      <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            sample_q     <= '0;
            sample_cnt_q <= '0;
            to_q         <= 1'b0;
            ov_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            start_q      <= state_d == START_HI;
            oe_q         <= state_d == OE_HI;
            busy_q       <= state_d != IDLE;
            valid_q      <= state_q == CAPTURE;
            if (state_q == CAPTURE) sample_q <= adc.adc_data;
            sample_cnt_q <= sample_cnt_q + CNT_W'(state_q == CAPTURE);
            to_q         <= !err_clr && (to_q || to_set);
            ov_q         <= !err_clr && (ov_q || (req && state_q != IDLE));
        end
    end

    assign adc.adc_start = start_q;
    assign adc.adc_oe    = oe_q;
    assign sample        = sample_q;
    assign sample_valid  = valid_q;
    assign busy          = busy_q;
    assign timeout_err   = to_q;
    assign overrun_err   = ov_q;
    assign sample_cnt    = sample_cnt_q;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed checks of the ADC sequencer against hand-computed timing
module tb_adc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0, soft_trig = 1'b0, err_clr = 1'b0;
    logic        soft_trig2 = 1'b0, err_clr2 = 1'b0;
    logic [11:0] sample, sample2;
    logic [15:0] sample_cnt, sample_cnt2;
    logic        sample_valid, busy, timeout_err, overrun_err;
    logic        sample_valid2, busy2, timeout_err2, overrun_err2;
    logic        use_model = 1'b1, eoc_man = 1'b1, eoc_m;
    logic [11:0] data_v = 12'hA5C;
    int          conv_t = 20, conv_left;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    adc_seq_ctrl_if bus();
    adc_seq_ctrl_if bus2();

    assign bus.adc_eoc   = use_model ? eoc_m : eoc_man;
    assign bus.adc_data  = data_v;
    assign bus2.adc_eoc  = 1'b1;
    assign bus2.adc_data = 12'h3C3;

    adc_seq_ctrl #(.SAMPLE_PERIOD(50)) dut (
        .clk(clk), .rstn(rstn), .en(en), .soft_trig(soft_trig), .err_clr(err_clr),
        .adc(bus), .sample(sample), .sample_valid(sample_valid), .busy(busy),
        .timeout_err(timeout_err), .overrun_err(overrun_err), .sample_cnt(sample_cnt)
    );

    adc_seq_ctrl #(.TIMEOUT(15)) dut2 (
        .clk(clk), .rstn(rstn), .en(1'b0), .soft_trig(soft_trig2), .err_clr(err_clr2),
        .adc(bus2), .sample(sample2), .sample_valid(sample_valid2), .busy(busy2),
        .timeout_err(timeout_err2), .overrun_err(overrun_err2), .sample_cnt(sample_cnt2)
    );

    // ADC model: EOC drops the cycle after start is seen and rises conv_t cycles later
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eoc_m     <= 1'b1;
            conv_left <= 0;
        end else if (conv_left == 0) begin
            if (bus.adc_start && eoc_m) begin
                eoc_m     <= 1'b0;
                conv_left <= conv_t;
            end
        end else if (conv_left == 1) begin
            eoc_m     <= 1'b1;
            conv_left <= 0;
        end else begin
            conv_left <= conv_left - 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = sample_valid;
        end
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if ({bus.adc_start, bus.adc_oe, sample_valid, busy, timeout_err, overrun_err, sample, sample_cnt} !== 34'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0", {bus.adc_start, bus.adc_oe, sample_valid, busy, timeout_err, overrun_err, sample, sample_cnt});
        end
        tests++;
        if ({bus2.adc_start, bus2.adc_oe, sample_valid2, busy2, timeout_err2, overrun_err2, sample2, sample_cnt2} !== 34'd0) begin
            fails++;
            $display("FAIL reset_outputs2: got %h required 0", {bus2.adc_start, bus2.adc_oe, sample_valid2, busy2, timeout_err2, overrun_err2, sample2, sample_cnt2});
        end
        repeat (3) step();
        rstn = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 60; k++) begin
                step();
                seen |= busy;
            end
            tests++;
            if (seen !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_tick: busy seen=%0b required 0 with en=0", seen);
            end
        end
    endtask

    task automatic test_periodic;
        int nv = 0;
        int vt[3];
        data_v = 12'hA5C;
        step();
        en = 1'b1;
        for (int k = 1; k <= 190; k++) begin
            step();
            if (sample_valid) begin
                if (nv < 3) vt[nv] = k;
                nv++;
                tests++;
                if ({sample, sample_cnt} !== {12'hA5C, 16'(nv)}) begin
                    fails++;
                    $display("FAIL periodic_sample%0d: got %h/%0d required a5c/%0d", nv, sample, sample_cnt, nv);
                end
            end
        end
        en = 1'b0;
        tests++;
        if (nv !== 3) begin
            fails++;
            $display("FAIL periodic_count: got %0d valids required 3", nv);
        end else begin
            tests++;
            if (vt[0] !== 75) begin
                fails++;
                $display("FAIL periodic_first: got cycle %0d required 75", vt[0]);
            end
            tests++;
            if (vt[1] - vt[0] !== 50 || vt[2] - vt[1] !== 50) begin
                fails++;
                $display("FAIL periodic_spacing: got %0d,%0d required 50,50", vt[1] - vt[0], vt[2] - vt[1]);
            end
        end
    endtask

    task automatic test_soft_trig;
        logic [2:0] exp_v;
        data_v    = 12'h5A3;
        use_model = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            step();
            soft_trig = (k == 10);
            eoc_man   = !(k >= 14 && k < 30);
            exp_v     = {k == 11 || k == 12, k == 31 || k == 32, k == 34};
            tests++;
            if ({bus.adc_start, bus.adc_oe, sample_valid} !== exp_v) begin
                fails++;
                $display("FAIL soft_trig_c%0d: start/oe/valid got %b required %b", k, {bus.adc_start, bus.adc_oe, sample_valid}, exp_v);
            end
            if (k == 34) begin
                tests++;
                if ({sample, sample_cnt} !== {12'h5A3, 16'd4}) begin
                    fails++;
                    $display("FAIL soft_trig_sample: got %h/%0d required 5a3/4", sample, sample_cnt);
                end
            end
        end
        use_model = 1'b1;
        eoc_man   = 1'b1;
        data_v    = 12'hA5C;
    endtask

    task automatic test_overrun;
        logic [15:0] cnt0 = sample_cnt;
        int nv = 0;
        bit ok;
        for (int k = 0; k < 60; k++) begin
            step();
            soft_trig = (k == 0) || (k == 5);
            if (k == 5) begin
                tests++;
                if ({busy, overrun_err} !== 2'b10) begin
                    fails++;
                    $display("FAIL overrun_pre: busy/ovr got %b required 10", {busy, overrun_err});
                end
            end
            if (k == 6) begin
                tests++;
                if (overrun_err !== 1'b1) begin
                    fails++;
                    $display("FAIL overrun_set: got %b required 1", overrun_err);
                end
            end
            if (sample_valid) nv++;
        end
        tests++;
        if (nv !== 1 || sample_cnt !== cnt0 + 16'd1) begin
            fails++;
            $display("FAIL overrun_single: valids %0d cnt %0d required 1 and %0d", nv, sample_cnt, cnt0 + 16'd1);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            soft_trig = (k == 0) || (k == 3);
            err_clr   = (k == 3);
            if (k == 4) begin
                tests++;
                if (overrun_err !== 1'b0) begin
                    fails++;
                    $display("FAIL overrun_clr_priority: got %b required 0", overrun_err);
                end
            end
        end
        wait_valid(ok);
        tests++;
        if (!ok || sample_cnt !== cnt0 + 16'd2) begin
            fails++;
            $display("FAIL overrun_second: valid %0b cnt %0d required 1 and %0d", ok, sample_cnt, cnt0 + 16'd2);
        end
    endtask

    task automatic test_timeout;
        int nv = 0;
        step();
        soft_trig2 = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            soft_trig2 = 1'b0;
            if (k == 17 || k == 18) begin
                tests++;
                if ({busy2, timeout_err2} !== (k == 17 ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("FAIL timeout_c%0d: busy/to got %b required %b", k, {busy2, timeout_err2}, k == 17 ? 2'b10 : 2'b01);
                end
            end
            if (sample_valid2) nv++;
        end
        tests++;
        if (nv !== 0 || sample2 !== 12'h000 || sample_cnt2 !== 16'd0 || timeout_err2 !== 1'b1) begin
            fails++;
            $display("FAIL timeout_nosample: valids %0d sample %h cnt %0d to %b required 0 000 0 1", nv, sample2, sample_cnt2, timeout_err2);
        end
        err_clr2 = 1'b1;
        step();
        err_clr2 = 1'b0;
        tests++;
        if (timeout_err2 !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: got %b required 0", timeout_err2);
        end
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        step();
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = bus.adc_oe;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_mid_reach_oe: adc_oe got 0 required 1 within 60 cycles");
        end
        #2 rstn = 1'b0;
        #1;
        tests++;
        if ({bus.adc_oe, bus.adc_start, busy, sample, sample_cnt} !== 31'd0) begin
            fails++;
            $display("FAIL reset_mid_async: oe/start/busy/sample/cnt got %b %b %b %h %0d required 0", bus.adc_oe, bus.adc_start, busy, sample, sample_cnt);
        end
        step();
        rstn = 1'b1;
        step();
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        wait_valid(ok);
        tests++;
        if (!ok || sample !== 12'hA5C || sample_cnt !== 16'd1) begin
            fails++;
            $display("FAIL reset_mid_recover: valid %0b sample %h cnt %0d required 1 a5c 1", ok, sample, sample_cnt);
        end
    endtask

    task automatic test_wrap_back_to_back;
        bit ok;
        conv_t = 4;
        force dut.sample_cnt_q = 16'hFFFF;
        #1 release dut.sample_cnt_q;
        step();
        tests++;
        if (sample_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: got %0d required 65535", sample_cnt);
        end
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        wait_valid(ok);
        tests++;
        if (!ok || sample_cnt !== 16'd0) begin
            fails++;
            $display("FAIL wrap_zero: valid %0b cnt %0d required 1 and 0", ok, sample_cnt);
        end
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        tests++;
        if ({bus.adc_start, overrun_err} !== 2'b10) begin
            fails++;
            $display("FAIL back_to_back_accept: start/ovr got %b required 10", {bus.adc_start, overrun_err});
        end
        wait_valid(ok);
        tests++;
        if (!ok || sample_cnt !== 16'd1) begin
            fails++;
            $display("FAIL back_to_back_cnt: valid %0b cnt %0d required 1 and 1", ok, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_soft_trig();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_wrap_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
